// File: rtl/d_flip_flop_pkg.sv
// ---------------------------------------------------------------------------
// d_flip_flop_pkg
// Shared constants for the D flip-flop storage slice. The stored value and
// its reset value are module parameters. This package holds only the
// default width and the legal width bounds, so the interface and the top
// agree on them.
// ---------------------------------------------------------------------------
package d_flip_flop_pkg;

  // Default word width: a single storage bit.
  localparam int unsigned DEFAULT_WIDTH = 1;

  // Legal width range for a register word built from flop cells.
  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 64;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_if.sv
// ---------------------------------------------------------------------------
// d_flip_flop_if
// Data bundle of a D flip-flop word. Clock and reset stay plain ports on the
// flop, so they are not part of this bundle.
//   D   data to capture (driven by the producer)
//   Q   stored value (driven by the flop)
//   Qn  bitwise complement of Q (driven by the flop)
// Modports:
//   master  producer side: drives D, observes Q/Qn
//   slave   flop side: reads D, drives Q/Qn
// ---------------------------------------------------------------------------
interface d_flip_flop_if
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;

  modport master (
    output D,
    input  Q,
    input  Qn
  );

  modport slave (
    input  D,
    output Q,
    output Qn
  );

endinterface : d_flip_flop_if

// File: rtl/d_flip_flop_cell.sv
// ---------------------------------------------------------------------------
// d_ff_cell
// One-bit positive-edge D flop with synchronous active-high reset.
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous reset, active-high, sampled only at the edge
//   D          data bit to capture
//   Q          stored bit
//   Qn         complement of Q
// Parameter RESET_VAL is the bit loaded into Q while Rst is high at an edge.
// ---------------------------------------------------------------------------
module d_ff_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic D,
  output logic Q,
  output logic Qn
);

  logic r_q;

  // Storage bit. Reset is checked first, so it wins over D at the same edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= D;
    end
  end

  // Qn comes from the same register as Q, not from a second flop, so the two
  // outputs can never disagree. An unknown Q also gives an unknown Qn.
  assign Q  = r_q;
  assign Qn = ~r_q;

endmodule : d_ff_cell

// File: rtl/d_flip_flop.sv
// ---------------------------------------------------------------------------
// d_flip_flop
// WIDTH-bit positive-edge D register made of independent one-bit cells.
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous reset, active-high; loads RESET_VAL
//   bus.D      data word to capture (WIDTH bits)
//   bus.Q      stored word (WIDTH bits)
//   bus.Qn     bitwise complement of the stored word (WIDTH bits)
// Parameters:
//   WIDTH      number of stored bits, 1..64
//   RESET_VAL  word loaded into Q on reset; bit i goes to cell i
// ---------------------------------------------------------------------------
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           Clk,
  input  logic           Rst,
  d_flip_flop_if.slave   bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;

  // Each bit has its own cell with its own reset bit. No enable and no
  // coupling between bits, so every edge reloads every bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : gCell
    d_ff_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) uCell (
      .Clk (Clk),
      .Rst (Rst),
      .D   (bus.D[i]),
      .Q   (w_q[i]),
      .Qn  (w_qn[i])
    );
  end

  assign bus.Q  = w_q;
  assign bus.Qn = w_qn;

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_d_flip_flop
// Directed and random bench for d_flip_flop. Three instances share clock and
// reset:
//   u1  WIDTH=1, RESET_VAL=0
//   u2  WIDTH=1, RESET_VAL=1
//   u8  WIDTH=8, RESET_VAL=8'hA5
// Expected values go into a queue before each rising edge and come out of it
// just after the edge.
// ---------------------------------------------------------------------------
module tb_d_flip_flop;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic       q1[$];
  logic       q2[$];
  logic [7:0] q8[$];

  d_flip_flop_if #(.WIDTH(1)) bus1();
  d_flip_flop_if #(.WIDTH(1)) bus2();
  d_flip_flop_if #(.WIDTH(8)) bus8();

  d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) u1 (.Clk(clk), .Rst(rst), .bus(bus1));
  d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b1)) u2 (.Clk(clk), .Rst(rst), .bus(bus2));
  d_flip_flop #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (.Clk(clk), .Rst(rst), .bus(bus8));

  // 60 ns period, first rising edge at 30 ns.
  initial clk = 1'b0;
  always #30 clk = ~clk;

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic d, input logic [7:0] d8);
    rst = r;
    bus1.D = d;
    bus2.D = d;
    bus8.D = d8;
  endtask

  task automatic checkOutput(input string tag);
    logic       e1;
    logic       e2;
    logic [7:0] e8;
    if (q1.size() == 0 || q2.size() == 0 || q8.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      e8 = q8.pop_front();
      compare({tag, "_u1_Q"},  {7'b0, bus1.Q},  {7'b0, e1});
      compare({tag, "_u1_Qn"}, {7'b0, bus1.Qn}, {7'b0, ~e1});
      compare({tag, "_u2_Q"},  {7'b0, bus2.Q},  {7'b0, e2});
      compare({tag, "_u2_Qn"}, {7'b0, bus2.Qn}, {7'b0, ~e2});
      compare({tag, "_u8_Q"},  bus8.Q,  e8);
      compare({tag, "_u8_Qn"}, bus8.Qn, ~e8);
    end
  endtask

  // Push the model value for the coming edge from the current inputs, then
  // check 1 ns after that edge.
  task automatic clockEdge(input string tag);
    q1.push_back(rst ? 1'b0  : bus1.D);
    q2.push_back(rst ? 1'b1  : bus2.D);
    q8.push_back(rst ? 8'hA5 : bus8.D);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    // t=0: D=1, Rst low
    applyStimulus(1'b0, 1'b1, 8'h00);
    clockEdge("edge30");                     // t=31
    #19 applyStimulus(1'b0, 1'b0, 8'h00);    // t=50
    clockEdge("edge90");                     // t=91
    #9 applyStimulus(1'b0, 1'b1, 8'h00);     // t=100
    clockEdge("edge150");                    // t=151
    clockEdge("hold210");                    // t=211

    // Mid-cycle glitch on D must not disturb Q.
    #10 applyStimulus(1'b0, 1'b0, 8'hFF);    // t=221
    #5 applyStimulus(1'b0, 1'b1, 8'h00);     // t=226
    #2;                                      // t=228
    compare("glitch_u1_Q", {7'b0, bus1.Q}, 8'h01);
    compare("glitch_u8_Q", bus8.Q, 8'h00);
    clockEdge("after_glitch");               // t=271

    // Rst asserted mid-cycle acts only at the next edge.
    #10 rst = 1'b1;                          // t=281
    #48;                                     // t=329
    compare("rst_midcycle_u1_Q", {7'b0, bus1.Q}, 8'h01);
    compare("rst_midcycle_u8_Q", bus8.Q, 8'h00);
    clockEdge("rst_edge");                   // t=331
    #19 applyStimulus(1'b0, 1'b1, 8'h3C);    // t=350
    clockEdge("rst_release");                // t=391

    // Reset priority over D at the same edge.
    applyStimulus(1'b1, 1'b1, 8'hFF);
    clockEdge("prio_d1");
    applyStimulus(1'b1, 1'b0, 8'h00);
    clockEdge("prio_d0");
    applyStimulus(1'b0, 1'b0, 8'h3C);
    clockEdge("wide_load");

    // Random data with random reset pulses.
    for (int i = 0; i < 1000; i++) begin
      #10 applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)));
      clockEdge("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_d_flip_flop
